bit_reg: RTL and testbench

BIT_REG -- requirements
Module: bit_reg

---
 rtl/bit_reg.sv | 46 ++++
 tb/tb_bit_reg.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bit_reg.sv
`timescale 1ns/1ps
// bit_reg: WIDTH-bit storage register with load enable.
//
// Holds a value that is written on a rising clk edge when load is high and
// held otherwise. An asynchronous active-low reset returns the register to
// RESET_VALUE and clears the loaded flag without waiting for a clock edge.
//
// Ports
//   clk     in   1      sole clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   in      in   WIDTH  data to store
//   load    in   1      write enable, sampled on the rising edge of clk
//   out     out  WIDTH  stored value, straight from the flops
//   loaded  out  1      high once at least one load has completed since reset
module bit_reg #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   output logic [WIDTH-1:0] out,
   output logic             loaded
);

   generate
      if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
         $error("bit_reg: WIDTH must be in 1..64");
      end
   endgenerate

   // Outputs are the flops themselves, so there is no combinational path
   // from in or load to out. Writing an identical value leaves every flop
   // at the same level, so a same-value reload cannot glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out    <= RESET_VALUE;
         loaded <= 1'b0;
      end else if (load) begin
         out    <= in;
         loaded <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bit_reg.sv
`timescale 1ns/1ps
module tb_bit_reg;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic       load;
   logic       in1;
   logic [7:0] in8;
   logic       out1;
   logic       loaded1;
   logic [7:0] out8;
   logic       loaded8;

   int n_chk;
   int n_pass;

   bit_reg u_dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in1),
      .load   (load),
      .out    (out1),
      .loaded (loaded1)
   );

   bit_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in8),
      .load   (load),
      .out    (out8),
      .loaded (loaded8)
   );

   // 10 ns period; clk_en lets the first reset check run with the clock stopped
   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One rising edge, then settle to 2 ns before the next edge
   task automatic tick;
      @(posedge clk);
      #8;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      clk_en = 1'b0;
      rst_n  = 1'b1;
      load   = 1'b0;
      in1    = 1'b1;
      in8    = 8'hFF;

      // reset with the clock stopped
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out1",    out1,    1'b0);
      chk("rst_loaded1", loaded1, 1'b0);
      chk("rst_out8",    out8,    8'hA5);
      chk("rst_loaded8", loaded8, 1'b0);
      #2 rst_n = 1'b1;
      #2 clk_en = 1'b1;

      // no load: values stay at reset
      load = 1'b0; in1 = 1'b1; in8 = 8'hFF;
      tick;
      chk("idle_out1",    out1,    1'b0);
      chk("idle_out8",    out8,    8'hA5);
      chk("idle_loaded1", loaded1, 1'b0);

      // load 1 / 8'h3C; nothing visible before the edge
      load = 1'b1; in1 = 1'b1; in8 = 8'h3C;
      #1;
      chk("pre_edge_out1", out1, 1'b0);
      chk("pre_edge_out8", out8, 8'hA5);
      tick;
      chk("load1_out1",    out1,    1'b1);
      chk("load1_loaded1", loaded1, 1'b1);
      chk("load_out8",     out8,    8'h3C);
      chk("load_loaded8",  loaded8, 1'b1);
      load = 1'b0; in1 = 1'b0; in8 = 8'hFF;
      tick;
      chk("hold1_out1", out1, 1'b1);
      chk("hold_out8",  out8, 8'h3C);

      // load pulse between edges must not matter
      in1 = 1'b0; load = 1'b1;
      #0.5 load = 1'b0;
      tick;
      chk("glitch_out1", out1, 1'b1);

      // load 0, then hold with in=1
      load = 1'b1; in1 = 1'b0;
      tick;
      chk("load0_out1", out1, 1'b0);
      load = 1'b0; in1 = 1'b1;
      tick;
      chk("hold0_out1",    out1,    1'b0);
      chk("hold0_loaded1", loaded1, 1'b1);

      // reload 1
      load = 1'b1; in1 = 1'b1;
      tick;
      chk("reload_out1", out1, 1'b1);
      load = 1'b0;
      tick;
      chk("reload_hold_out1", out1, 1'b1);

      // same-value reload
      load = 1'b1; in1 = 1'b1;
      tick;
      chk("same_out1", out1, 1'b1);

      // back-to-back loads, last wins
      in8 = 8'h11;
      tick;
      chk("b2b_first_out8", out8, 8'h11);
      in8 = 8'h22;
      tick;
      chk("b2b_last_out8", out8, 8'h22);

      // reset mid-cycle with a load pending
      load = 1'b1; in1 = 1'b1; in8 = 8'h77;
      #0.5 rst_n = 1'b0;
      #0.5;
      chk("mid_rst_out1",    out1,    1'b0);
      chk("mid_rst_loaded1", loaded1, 1'b0);
      chk("mid_rst_out8",    out8,    8'hA5);
      chk("mid_rst_loaded8", loaded8, 1'b0);
      tick;
      chk("in_rst_out1",    out1, 1'b0);
      chk("in_rst_out8",    out8, 8'hA5);
      load = 1'b0;
      rst_n = 1'b1;
      tick;
      chk("post_rst_out1",    out1,    1'b0);
      chk("post_rst_loaded1", loaded1, 1'b0);
      chk("post_rst_out8",    out8,    8'hA5);
      load = 1'b1; in1 = 1'b1; in8 = 8'h5A;
      tick;
      chk("post_rst_load_out1",    out1,    1'b1);
      chk("post_rst_load_loaded1", loaded1, 1'b1);
      chk("post_rst_load_out8",    out8,    8'h5A);
      load = 1'b0;
      tick;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
